// File: rtl/crc4_pkg.sv
// rtl/crc4_pkg.sv - shared types and widths for the CRC-4 check engine
package crc4_pkg;

    localparam int CRC_W  = 4;
    localparam int POLY_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } crc_state_t;

    typedef logic [CRC_W-1:0] crc_t;

endpackage

// File: rtl/crc4_step.sv
// rtl/crc4_step.sv - one serial CRC-4 division step (rem, bit, poly) -> next rem
module crc4_step
    import crc4_pkg::*;
(
    input  crc_t              i_rem,
    input  logic              i_bit,
    input  logic [POLY_W-1:0] i_poly,
    output crc_t              o_rem
);

    logic [POLY_W-1:0] t;

    // Shift the next message bit in; subtract the generator when the top bit is set.
    // A polynomial with bit 4 clear still follows the same rule.
    always_comb begin
        t = {i_rem, i_bit};
        if (t[POLY_W-1]) begin
            t = t ^ i_poly;
        end
        o_rem = t[CRC_W-1:0];
    end

endmodule

// File: rtl/crc4_check_ctrl.sv
// rtl/crc4_check_ctrl.sv - serial CRC-4 check controller; error counter under CRC4_CHECK_CTRL_ERRCNT_EN
module crc4_check_ctrl
    import crc4_pkg::*;
#(
    parameter int WCODE = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [WCODE-1:0]  i_data,
    input  logic [POLY_W-1:0] i_poly,
    input  logic [CRC_W-1:0]  i_crc,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CRC_W-1:0]  o_crc,
    output logic              o_err,
    output logic              o_busy,
    output logic [7:0]        o_err_cnt
);

    localparam int LEN   = WCODE + CRC_W;
    localparam int CNT_W = $clog2(LEN);

    crc_state_t        state_q, state_d;
    logic [LEN-1:0]    msg_q, msg_d;
    logic [POLY_W-1:0] poly_q, poly_d;
    crc_t              rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    crc_t              hold_crc_q, hold_crc_d;
    logic              hold_err_q, hold_err_d;
    crc_t              step_rem;
    logic              res_take;

    crc4_step u_step (
        .i_rem  (rem_q),
        .i_bit  (msg_q[LEN-1]),
        .i_poly (poly_q),
        .o_rem  (step_rem)
    );

    // A result leaves only when taken downstream and not aborted in the same cycle.
    assign res_take = (state_q == DONE) && i_ready && !i_flush;

    // Next-state and datapath updates: accept in IDLE, one division step per SHIFT cycle,
    // hand over the remainder in DONE.
    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        poly_d     = poly_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        hold_crc_d = hold_crc_q;
        hold_err_d = hold_err_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    msg_d   = {i_data, i_crc};
                    poly_d  = i_poly;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(LEN - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (i_flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    msg_d = msg_q << 1;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            DONE: begin
                if (i_flush) begin
                    state_d = IDLE;
                end else if (res_take) begin
                    hold_crc_d = rem_q;
                    hold_err_d = |rem_q;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            msg_q      <= '0;
            poly_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            hold_crc_q <= '0;
            hold_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            poly_q     <= poly_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            hold_crc_q <= hold_crc_d;
            hold_err_q <= hold_err_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q != IDLE);
    assign o_valid = (state_q == DONE);
    assign o_crc   = (state_q == DONE) ? rem_q  : hold_crc_q;
    assign o_err   = (state_q == DONE) ? |rem_q : hold_err_q;

`ifdef CRC4_CHECK_CTRL_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Count delivered erroneous results, saturating at 255.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (res_take && (rem_q != '0) && (err_cnt_q != 8'hff)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;
`else
    assign o_err_cnt = '0;
`endif

endmodule

// File: doc/crc4_check_ctrl.md
Name: crc4_check_ctrl

Overview:
- Sequential CRC-4 check engine for the ALU model.
- Accepts one codeword per transaction over a valid/ready handshake:
  - data word i_data
  - 5-bit generator polynomial i_poly
  - received 4-bit CRC i_crc
- Divides {i_data, i_crc} by i_poly serially, one bit per clock, then reports the 4-bit remainder and a pass/fail flag.
- Sits between the ALU operand/opcode front end and the result mux, so CRC checking shares the ALU's request/response flow.

Parameters:
- WCODE, 4, data word width in bits (legal range 1..16).
- LEN, WCODE+4, derived localparam: number of message bits shifted.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  controller can accept a request.
- i_data  input  WCODE  data word.
- i_poly  input  5  generator polynomial, bit 4 = x^4 coefficient.
- i_crc  input  4  received CRC appended to the data.
- i_flush  input  1  synchronous abort of the transaction in flight.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_crc  output  4  remainder.
- o_err  output  1  1 when the remainder is nonzero.
- o_busy  output  1  state is not IDLE.
- o_err_cnt  output  8  error count (optional feature).

Behaviour:
- Reset (async on i_rst_n low):
  - state IDLE; o_ready=1; o_valid=0; o_busy=0; o_crc=0; o_err=0; o_err_cnt=0.
  - Internal shift register, remainder register and counter all cleared.
  - Deassertion takes effect on the next rising edge.
- States: IDLE, SHIFT, DONE. o_ready=1 only in IDLE.
- IDLE:
  - Handshake i_valid&o_ready captures msg={i_data,i_crc}, the poly register, rem=0 and cnt=LEN-1.
  - Next state SHIFT.
- SHIFT, one step per clock:
  - b=msg[LEN-1]; t={rem,b}; if t[4] then t=t^poly; rem=t[3:0]; msg=msg<<1.
  - When cnt==0, go to DONE; otherwise cnt decrements.
  - Exactly LEN SHIFT cycles, so o_valid first rises LEN clocks after the accepting edge (8 for WCODE=4).
- DONE:
  - o_valid=1; o_crc=rem; o_err=|rem.
  - Outputs stay stable until i_valid... correction: until o_valid&i_ready, then return to IDLE.
  - A new request can be accepted no earlier than the cycle after the result is taken (no overlap).
- Polynomial with bit 4 = 0 is not rejected; the same step rule applies. Result is deterministic (remainder is then the message shifted through a 4-bit window with conditional XOR).
- i_poly and i_crc are sampled only at accept; later changes have no effect.
- i_flush:
  - In SHIFT or DONE: next state IDLE, o_valid drops, no result delivered, error count unchanged.
  - In IDLE: ignored.
  - i_flush wins over i_ready in the same cycle.
- o_crc/o_err hold their last delivered values in IDLE (cleared only by reset).

Optional Feature:
- Macro CRC4_CHECK_CTRL_ERRCNT_EN.
- When defined:
  - o_err_cnt increments on every result handshake with o_err=1.
  - Saturates at 255.
  - Reset-only clear.
- When undefined:
  - o_err_cnt is tied to 0 and no counter flops exist.
  - The port list is unchanged.

Decomposition:
- Package crc4_pkg holds:
  - localparams CRC_W=4, POLY_W=5.
  - typedef enum logic [1:0] crc_state_t {IDLE, SHIFT, DONE}.
  - typedef logic [CRC_W-1:0] crc_t.
- Sub-module crc4_step is natural: combinational (rem, bit, poly) -> next rem. It is reused by the controller and by the bench reference model.

Test Plan:
- Reset, then a single check:
  - Stimulus: data=4'b1011, poly=5'b10011, crc=4'b0000.
  - Required: o_valid 8 clocks after accept, o_crc=4'b1110, o_err=1.
- Good codeword:
  - Stimulus: data=4'b1011, poly=5'b10011, crc=4'b1110.
  - Required: o_crc=0, o_err=0; with the macro defined, o_err_cnt unchanged.
- Single-bit corruption:
  - Stimulus: crc=4'b1111, same data and poly.
  - Required: o_crc=4'b0001, o_err=1; with the macro defined, o_err_cnt increments by 1.
- Backpressure:
  - Stimulus: hold i_ready=0 for 5 cycles in DONE, toggle i_valid and i_data.
  - Required: o_valid, o_crc and o_err stable; o_ready=0; no new accept.
- Flush and reset mid-operation:
  - Stimulus: assert i_flush on the 3rd SHIFT cycle.
  - Required: IDLE next clock, no o_valid.
  - Stimulus: separately, drop i_rst_n mid-SHIFT.
  - Required: outputs at reset values immediately, without waiting for a clock.
- Saturation (macro defined):
  - Stimulus: 260 erroneous checks.
  - Required: o_err_cnt=255.
  - With the macro undefined, o_err_cnt stays 0 throughout.
